// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives imem, fills IF/ID.
// Handles decode stall, redirect/flush and halt-on-opcode.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [2:0]        HALT_OP  = 3'b111
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic               halted_o
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0]  r_ifpc;
  logic [ADDR_W-1:0]  w_ifpc_nxt;
  logic               w_is_halt;

  assign w_is_halt = (imem_instr[INSTR_W-1 -: 3] == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ifpc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_ifpc  <= w_ifpc_nxt;
    end
  end

  // Redirect beats stall; the memory word of a redirect cycle is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_ifpc_nxt  = r_ifpc;
    if (redirect_valid_i) begin
      w_pc_nxt    = redirect_pc_i;
      w_valid_nxt = 1'b0;
      w_state_nxt = RUN;
    end else if (!stall_i) begin
      unique case (r_state)
        RUN: begin
          w_instr_nxt = imem_instr;
          w_ifpc_nxt  = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + 1'b1;
          if (w_is_halt) begin
            w_state_nxt = HALTED;
          end
        end
        HALTED: begin
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign if_valid_o = r_valid;
  assign if_instr_o = r_instr;
  assign if_pc_o    = r_ifpc;
  assign halted_o   = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal checks plus
// randomized stall/redirect traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [9:0]  redirect_pc_i;
  logic        if_valid_o;
  logic [15:0] if_instr_o;
  logic [9:0]  if_pc_o;
  logic        halted_o;

  logic [15:0] mem [1024];
  assign imem_instr = mem[imem_addr];

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .if_valid_o       (if_valid_o),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o),
    .halted_o         (halted_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch stage outputs
  logic [9:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [9:0]  m_ipc;
  logic        m_halted;
  logic        chk_en = 1'b0;

  task automatic model_reset();
    m_pc     = 10'd0;
    m_valid  = 1'b0;
    m_instr  = 16'd0;
    m_ipc    = 10'd0;
    m_halted = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic rv,
                            input logic [9:0] rpc);
    if (rv) begin
      m_pc     = rpc;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (!m_halted) begin
      m_instr = mem[m_pc];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 10'd1;
      if (m_instr[15:13] == 3'b111) m_halted = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("if_valid", 32'(if_valid_o), 32'(m_valid));
      check("halted", 32'(halted_o), 32'(m_halted));
      if (m_valid || !rst_n) begin
        check("if_instr", 32'(if_instr_o), 32'(m_instr));
        check("if_pc", 32'(if_pc_o), 32'(m_ipc));
      end
    end
  end

  // Drive inputs, take one edge, advance the model; returns at edge+1
  task automatic cycle(input logic st, input logic rv,
                       input logic [9:0] rpc);
    stall_i          = st;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    @(posedge clk);
    model_edge(st, rv, rpc);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h4C06; mem[1] = 16'h4504; mem[2] = 16'h0083;
    mem[3] = 16'h7082; mem[4] = 16'h6581; mem[5] = 16'h9401;
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    #2;
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_instr", 32'(if_instr_o), 32'd0);
    check("rst_pc", 32'(if_pc_o), 32'd0);
    check("rst_halt", 32'(halted_o), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // straight-line run
    cycle(0, 0, 0);
    check("run0_pc", 32'(if_pc_o), 32'd0);
    check("run0_instr", 32'(if_instr_o), 32'h4C06);
    check("run0_valid", 32'(if_valid_o), 32'd1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("run2_instr", 32'(if_instr_o), 32'h0083);

    // stall holds everything
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      check("stall_pc", 32'(if_pc_o), 32'd2);
      check("stall_instr", 32'(if_instr_o), 32'h0083);
      check("stall_addr", 32'(imem_addr), 32'd3);
    end
    cycle(0, 0, 0);
    check("unstall_pc", 32'(if_pc_o), 32'd3);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("run5_instr", 32'(if_instr_o), 32'h9401);

    // redirect wins over stall
    cycle(1, 1, 10'h200);
    check("redir_addr", 32'(imem_addr), 32'h200);
    check("redir_valid", 32'(if_valid_o), 32'd0);
    cycle(0, 0, 0);
    check("redir_pc", 32'(if_pc_o), 32'h200);
    check("redir_v1", 32'(if_valid_o), 32'd1);

    // wrap at top of memory
    cycle(0, 1, 10'h3FF);
    cycle(0, 0, 0);
    check("wrap_pc0", 32'(if_pc_o), 32'h3FF);
    cycle(0, 0, 0);
    check("wrap_pc1", 32'(if_pc_o), 32'h000);
    check("wrap_addr", 32'(imem_addr), 32'h001);

    // halt
    mem[3] = 16'hE000;
    cycle(0, 1, 10'h000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    check("halt_instr", 32'(if_instr_o), 32'hE000);
    check("halt_flag", 32'(halted_o), 32'd1);
    check("halt_valid", 32'(if_valid_o), 32'd1);
    cycle(0, 0, 0);
    check("halt_drop", 32'(if_valid_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      check("halt_addr", 32'(imem_addr), 32'd4);
    end
    cycle(0, 1, 10'h000);
    check("unhalt", 32'(halted_o), 32'd0);
    cycle(0, 0, 0);
    check("resume_pc", 32'(if_pc_o), 32'd0);
    check("resume_v", 32'(if_valid_o), 32'd1);

    // randomized traffic
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            10'($urandom));
    end

    // asynchronous reset mid-run
    cycle(0, 1, 10'h123);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_valid", 32'(if_valid_o), 32'd0);
    check("arst_halt", 32'(halted_o), 32'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            10'($urandom));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit processor. It owns the program counter, drives the instruction memory address, and captures the returned 16-bit instruction into the IF/ID pipeline register for the decode stage. It supports decode back-pressure (stall), control-flow redirect with flush, and halt on a HALT opcode. The instruction memory is a combinational-read array: the address is presented and the instruction returns in the same cycle.

## Interface
- ADDR_W, 10, instruction address width (1024-word memory)
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- HALT_OP, 3'b111, opcode field value (instr[15:13]) that halts fetch

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  address to instruction memory; always equals the PC register
- imem_instr  in  INSTR_W  instruction from memory at imem_addr, same cycle
- stall_i  in  1  decode cannot accept; hold the PC and IF/ID register
- redirect_valid_i  in  1  load a new PC and flush IF/ID
- redirect_pc_i  in  ADDR_W  redirect target
- if_valid_o  out  1  IF/ID register holds a valid instruction
- if_instr_o  out  INSTR_W  IF/ID instruction
- if_pc_o  out  ADDR_W  address from which if_instr_o was fetched
- halted_o  out  1  fetch is in the HALTED state

## Operation
- Reset is asynchronous, active-low. Values while asserted:
  - pc = RESET_PC
  - if_valid_o = 0, if_instr_o = 0, if_pc_o = 0
  - halted_o = 0
  - state = RUN
- FSM has 2 states: RUN and HALTED. halted_o = (state == HALTED).
- Per-edge priority, highest first:
  1. Redirect (any state, ignores stall): pc <= redirect_pc_i, if_valid_o <= 0, state <= RUN. The memory output for that cycle is discarded.
  2. stall_i = 1: pc, IF/ID register and state all hold.
  3. RUN: if_instr_o <= imem_instr, if_pc_o <= pc, if_valid_o <= 1, pc <= pc + 1. If imem_instr[15:13] == HALT_OP, also state <= HALTED. The HALT instruction itself is delivered to decode.
  4. HALTED: if_valid_o <= 0. pc, if_instr_o and if_pc_o hold.
- PC arithmetic is modulo 2^ADDR_W. 1023 + 1 wraps to 0 with no flag.
- Only a redirect or a reset leaves HALTED.
- stall_i is honoured even when if_valid_o = 0: everything holds.

## Timing
- Fetch latency is 1 cycle: the instruction at imem_addr is visible on if_instr_o after the next rising edge.
- Throughput is 1 instruction per cycle when not stalled.
- First edge after rst_n deasserts captures mem[RESET_PC]. if_valid_o rises on that edge.
- Redirect costs exactly 1 bubble cycle:
  - Edge N: redirect sampled; if_valid_o = 0 after edge N.
  - Edge N+1: the target instruction is captured.
- halted_o rises on the same edge that captures the HALT instruction. if_valid_o drops on the next non-stalled edge.
- imem_addr is a registered output; it changes only on clock edges or on asynchronous reset.
- Asserting rst_n low mid-operation forces all reset values immediately, without waiting for a clock.

## Test plan
- Reset then run, mem[0..5] = 0x4C06, 0x4504, 0x0083, 0x7082, 0x6581, 0x9401: on consecutive edges if_pc_o = 0..5 with matching if_instr_o; if_valid_o = 1 from the first edge.
- stall_i high for 3 cycles while if_pc_o = 2: if_instr_o = 0x0083, if_pc_o = 2 and imem_addr = 3 all hold. When stall_i drops, the next edge gives if_pc_o = 3.
- redirect_valid_i = 1 with redirect_pc_i = 0x200 and stall_i = 1: after the edge, imem_addr = 0x200 and if_valid_o = 0. The following edge gives if_pc_o = 0x200 and if_valid_o = 1.
- Wrap: redirect to 0x3FF. The next two captures give if_pc_o = 0x3FF then 0x000; imem_addr after that is 0x001.
- Halt, mem[3] = 0xE000:
  - The edge capturing pc 3 gives if_instr_o = 0xE000 and halted_o = 1.
  - The next edge gives if_valid_o = 0; imem_addr stays 4 for 10 cycles.
  - Redirect to 0 clears halted_o and resumes fetch at 0.
- Assert rst_n low asynchronously mid-run at pc = 0x123: imem_addr = RESET_PC, if_valid_o = 0 and halted_o = 0 before any clock edge.
